// File: rtl/fifo8x9_ctrl_pkg.sv
// Shared types and sizing for the FIFO8x9 sequencing controller.
package fifo8x9_ctrl_pkg;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned WIDTH = 9;
  localparam int unsigned PTR_W = 3;

  // Last addressable slot of the datapath; its pointers must never pass it.
  localparam logic [PTR_W-1:0] PTR_LAST   = PTR_W'(DEPTH - 1);
  localparam logic [PTR_W:0]   COUNT_FULL = (PTR_W + 1)'(DEPTH);

  typedef enum logic [1:0] {
    INIT,
    RUN,
    FLUSH
  } state_e;

endpackage

// File: rtl/fifo8x9_ctrl.sv
// Sequencing controller for one FIFO8x9 datapath: turns req/ack push and
// valid/req pop handshakes into raw pointer/write/read strobes, keeps shadow
// pointers plus an occupancy count, and handles pointer wrap on the datapath's
// behalf.
module fifo8x9_ctrl
  import fifo8x9_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push_req,
  input  logic [WIDTH-1:0] push_data,
  output logic             push_ack,
  input  logic             pop_req,
  output logic [WIDTH-1:0] pop_data,
  output logic             pop_valid,
  output logic [PTR_W:0]   count,
  output logic             full,
  output logic             empty,
  output logic             ovf,
  output logic             udf,
  output logic             fifo_rst,
  output logic             rd_clr,
  output logic             wr_clr,
  output logic             rd_inc,
  output logic             wr_inc,
  output logic             fifo_wren,
  output logic             fifo_rden,
  output logic [WIDTH-1:0] fifo_din,
  input  logic [WIDTH-1:0] fifo_dout
);

  state_e           state_q, state_d;
  logic [PTR_W-1:0] wptr_q, wptr_d;
  logic [PTR_W-1:0] rptr_q, rptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             wrap_pend_q, wrap_pend_d;
  logic             ovf_q, ovf_d;
  logic             udf_q, udf_d;

  logic in_init;
  logic in_run;
  logic in_flush;
  logic flush_now;
  logic run_act;
  logic full_int;
  logic empty_int;
  logic pop_fire;

  assign in_init   = !rst || (state_q == INIT);
  assign in_run    = rst && (state_q == RUN);
  assign in_flush  = rst && (state_q == FLUSH);
  assign flush_now = in_run && flush;
  assign run_act   = in_run && !flush;
  assign full_int  = (count_q == COUNT_FULL);
  assign empty_int = (count_q == '0);

  assign fifo_din  = push_data;
  assign pop_data  = fifo_dout;

  // Handshakes, status and datapath strobes, all combinational from state.
  always_comb begin
    push_ack  = run_act && push_req && !full_int;
    pop_valid = run_act && !empty_int;
    pop_fire  = pop_valid && pop_req;

    count     = in_init ? '0 : count_q;
    full      = !in_init && full_int;
    empty     = in_init || empty_int;
    ovf       = !in_init && ovf_q;
    udf       = !in_init && udf_q;

    fifo_rst  = in_init;
    // Bus is only driven while there is a valid head word.
    fifo_rden = in_init || empty_int;
    fifo_wren = push_ack;
    wr_inc    = push_ack && (wptr_q != PTR_LAST);
    rd_inc    = pop_fire && (rptr_q != PTR_LAST);

    // The datapath clears before it writes, so a write-pointer wrap is
    // applied one RUN cycle late; a push in that cycle lands in slot 0.
    wr_clr    = in_init || in_flush || flush_now || (in_run && wrap_pend_q);
    // Read wrap is immediate: clearing replaces the increment out of slot 7.
    rd_clr    = in_init || in_flush || flush_now ||
                (pop_fire && (rptr_q == PTR_LAST));
  end

  // Next-state logic for the sequencer, shadow pointers, count and sticky flags.
  always_comb begin
    state_d     = state_q;
    wptr_d      = wptr_q;
    rptr_d      = rptr_q;
    count_d     = count_q;
    wrap_pend_d = wrap_pend_q;
    ovf_d       = ovf_q;
    udf_d       = udf_q;

    unique case (state_q)
      INIT: begin
        state_d     = RUN;
        wptr_d      = '0;
        rptr_d      = '0;
        count_d     = '0;
        wrap_pend_d = 1'b0;
        ovf_d       = 1'b0;
        udf_d       = 1'b0;
      end
      RUN: begin
        if (flush) begin
          state_d     = FLUSH;
          wptr_d      = '0;
          rptr_d      = '0;
          count_d     = '0;
          wrap_pend_d = 1'b0;
          ovf_d       = 1'b0;
          udf_d       = 1'b0;
        end else begin
          wrap_pend_d = push_ack && (wptr_q == PTR_LAST);
          if (push_ack) begin
            wptr_d = (wptr_q == PTR_LAST) ? '0 : wptr_q + 1'b1;
          end
          if (pop_fire) begin
            rptr_d = (rptr_q == PTR_LAST) ? '0 : rptr_q + 1'b1;
          end
          if (push_ack && !pop_fire) begin
            count_d = count_q + 1'b1;
          end else if (pop_fire && !push_ack) begin
            count_d = count_q - 1'b1;
          end
          if (push_req && full_int) begin
            ovf_d = 1'b1;
          end
          if (pop_req && empty_int) begin
            udf_d = 1'b1;
          end
        end
      end
      FLUSH: begin
        state_d     = RUN;
        wptr_d      = '0;
        rptr_d      = '0;
        count_d     = '0;
        wrap_pend_d = 1'b0;
        ovf_d       = 1'b0;
        udf_d       = 1'b0;
      end
      default: begin
        state_d = INIT;
      end
    endcase
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= INIT;
      wptr_q      <= '0;
      rptr_q      <= '0;
      count_q     <= '0;
      wrap_pend_q <= 1'b0;
      ovf_q       <= 1'b0;
      udf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      count_q     <= count_d;
      wrap_pend_q <= wrap_pend_d;
      ovf_q       <= ovf_d;
      udf_q       <= udf_d;
    end
  end

endmodule
